// File: rtl/ov_cfg_ctrl.sv
// ov_cfg_ctrl: power-up register configuration sequencer for the camera sensor.
//
// Walks a register table held in a synchronous ROM and issues one 3-phase SCCB
// write (ID byte, register address, register value) per entry. When the whole
// table has been written it raises cfg_done, which gates the pixel capture path.
// This block is the sole owner of the sensor SIOC/SIOD pins.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   start     in   one-cycle request to run the table; ignored while busy
//   rom_addr  out  ROM index (8 bits)
//   rom_data  in   {reg_addr[15:8], reg_value[7:0]}, valid 1 cycle after rom_addr
//   sioc      out  SCCB clock
//   siod_o    out  SCCB data out
//   siod_oe   out  SIOD drive enable; 0 releases the line to its pull-up
//   busy      out  high from start acceptance until DONE
//   cfg_done  out  level; configuration complete
//
// Optional feature macro: OV_CFG_DELAY_ENTRY_EN
//   When defined, a ROM entry with reg_addr 8'hFF issues no bus cycle; the block
//   instead waits reg_value * DELAY_UNIT cycles and then enters the inter-entry gap.
//   When undefined, such an entry is written to the sensor like any other.

module ov_cfg_ctrl #(
    parameter int unsigned CLK_DIV    = 250,
    parameter int unsigned REG_NUM    = 166,
    parameter logic [7:0]  DEV_ADDR   = 8'h42,
    parameter int unsigned BOOT_WAIT  = 1_000_000,
    parameter int unsigned DELAY_UNIT = 25_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe,
    output logic        busy,
    output logic        cfg_done
);

    typedef enum logic [3:0] {
        StIdle,
        StBoot,
        StFetch,
        StStart,
        StShift,
        StStop,
        StGap,
        StDone,
        StDelay
    } state_e;

    localparam logic [15:0] DivLast   = 16'(CLK_DIV - 1);
    localparam logic [15:0] GapLast   = 16'(4 * CLK_DIV - 1);
    localparam logic [19:0] BootLast  = 20'(BOOT_WAIT - 1);
    localparam logic [15:0] DelayLast = 16'(DELAY_UNIT - 1);
    localparam logic [8:0]  RegNum9   = 9'(REG_NUM);

    state_e      r_state;
    logic [15:0] r_div;
    logic [1:0]  r_qtr;     // SHIFT: quarter 0..3; START/STOP: bit 0 selects the half
    logic [4:0]  r_bit;     // 0..26 across the three 9-bit phases
    logic [19:0] r_boot;
    logic [23:0] r_sr;
    logic [7:0]  r_rom_addr;
    logic        r_sioc;
    logic        r_siod;
    logic        r_oe;

    state_e      w_state_d;
    logic [15:0] w_div_d;
    logic [1:0]  w_qtr_d;
    logic [4:0]  w_bit_d;
    logic [19:0] w_boot_d;
    logic [23:0] w_sr_d;
    logic [7:0]  w_addr_d;
    logic        w_sioc_d;
    logic        w_siod_d;
    logic        w_oe_d;
    logic        w_dc_q;
    logic        w_dc_d;

`ifdef OV_CFG_DELAY_ENTRY_EN
    logic [7:0]  r_tick;
    logic [7:0]  w_tick_d;
`else
    logic        w_unused_delay;
    assign w_unused_delay = ^DelayLast;
`endif

    // The 9th bit of each phase is the don't-care/ACK slot.
    function automatic logic is_dc(input logic [4:0] b);
        return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
    endfunction

    assign w_dc_q = is_dc(r_bit);

    always_comb begin
        w_state_d = r_state;
        w_div_d   = r_div;
        w_qtr_d   = r_qtr;
        w_bit_d   = r_bit;
        w_boot_d  = r_boot;
        w_sr_d    = r_sr;
        w_addr_d  = r_rom_addr;
`ifdef OV_CFG_DELAY_ENTRY_EN
        w_tick_d  = r_tick;
`endif

        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_d = StBoot;
                    w_boot_d  = '0;
                    w_addr_d  = '0;
                end
            end
            StBoot: begin
                if (r_boot == BootLast) begin
                    w_state_d = StFetch;
                    w_div_d   = '0;
                end else begin
                    w_boot_d = r_boot + 20'd1;
                end
            end
            StFetch: begin
                // Cycle 0 presents the address, cycle 1 sees the ROM word.
                if (r_div == '0) begin
                    w_div_d = 16'd1;
                end else begin
                    w_div_d   = '0;
                    w_qtr_d   = '0;
                    w_bit_d   = '0;
                    w_sr_d    = {DEV_ADDR, rom_data};
                    w_state_d = StStart;
`ifdef OV_CFG_DELAY_ENTRY_EN
                    if (rom_data[15:8] == 8'hFF) begin
                        w_tick_d  = '0;
                        w_state_d = (rom_data[7:0] == 8'd0) ? StGap : StDelay;
                    end
`endif
                end
            end
            StStart, StStop: begin
                if (r_div == DivLast) begin
                    w_div_d = '0;
                    if (r_qtr[0]) begin
                        w_qtr_d   = '0;
                        w_bit_d   = '0;
                        w_state_d = (r_state == StStart) ? StShift : StGap;
                    end else begin
                        w_qtr_d = 2'd1;
                    end
                end else begin
                    w_div_d = r_div + 16'd1;
                end
            end
            StShift: begin
                if (r_div == DivLast) begin
                    w_div_d = '0;
                    w_qtr_d = r_qtr + 2'd1;
                    if (r_qtr == 2'd3) begin
                        // Only real data bits consume the shift register.
                        if (!w_dc_q) begin
                            w_sr_d = {r_sr[22:0], 1'b0};
                        end
                        if (r_bit == 5'd26) begin
                            w_state_d = StStop;
                        end else begin
                            w_bit_d = r_bit + 5'd1;
                        end
                    end
                end else begin
                    w_div_d = r_div + 16'd1;
                end
            end
            StGap: begin
                if (r_div == GapLast) begin
                    w_div_d   = '0;
                    w_addr_d  = r_rom_addr + 8'd1;
                    w_state_d = (({1'b0, r_rom_addr} + 9'd1) == RegNum9) ? StDone : StFetch;
                end else begin
                    w_div_d = r_div + 16'd1;
                end
            end
`ifdef OV_CFG_DELAY_ENTRY_EN
            StDelay: begin
                if (r_div == DelayLast) begin
                    w_div_d = '0;
                    if (r_tick == (r_sr[7:0] - 8'd1)) begin
                        w_state_d = StGap;
                    end else begin
                        w_tick_d = r_tick + 8'd1;
                    end
                end else begin
                    w_div_d = r_div + 16'd1;
                end
            end
`endif
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Pin levels are decoded from the next state so they register in step with it.
        w_dc_d   = is_dc(w_bit_d);
        w_sioc_d = 1'b1;
        w_siod_d = 1'b1;
        w_oe_d   = 1'b1;
        case (w_state_d)
            StStart: begin
                w_siod_d = ~w_qtr_d[0];
            end
            StShift: begin
                w_sioc_d = w_qtr_d[1];
                w_siod_d = w_dc_d ? 1'b1 : w_sr_d[23];
                w_oe_d   = ~w_dc_d;
            end
            StStop: begin
                w_sioc_d = w_qtr_d[0];
                w_siod_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_div      <= '0;
            r_qtr      <= '0;
            r_bit      <= '0;
            r_boot     <= '0;
            r_sr       <= '0;
            r_rom_addr <= '0;
            r_sioc     <= 1'b1;
            r_siod     <= 1'b1;
            r_oe       <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_div      <= w_div_d;
            r_qtr      <= w_qtr_d;
            r_bit      <= w_bit_d;
            r_boot     <= w_boot_d;
            r_sr       <= w_sr_d;
            r_rom_addr <= w_addr_d;
            r_sioc     <= w_sioc_d;
            r_siod     <= w_siod_d;
            r_oe       <= w_oe_d;
        end
    end

`ifdef OV_CFG_DELAY_ENTRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= '0;
        end else begin
            r_tick <= w_tick_d;
        end
    end
`endif

    assign rom_addr = r_rom_addr;
    assign sioc     = r_sioc;
    assign siod_o   = r_siod;
    assign siod_oe  = r_oe;
    assign busy     = (r_state != StIdle) && (r_state != StDone);
    assign cfg_done = (r_state == StDone);

endmodule

// File: tb/tb_ov_cfg_ctrl.sv
// tb_ov_cfg_ctrl: directed self-checking bench for ov_cfg_ctrl.
// Small parameters (CLK_DIV=4, BOOT_WAIT=10, REG_NUM=3, DELAY_UNIT=5) and a
// three-entry ROM {12/80, FF/03, 11/04}. Honours OV_CFG_DELAY_ENTRY_EN.

module tb_ov_cfg_ctrl;

    localparam int unsigned ClkDiv    = 4;
    localparam int unsigned RegNum    = 3;
    localparam int unsigned BootWait  = 10;
    localparam int unsigned DelayUnit = 5;

`ifdef OV_CFG_DELAY_ENTRY_EN
    localparam int NWrites     = 2;
    localparam int RunCycles   = 10 + 466 + (2 + 15 + 16) + 466;
    localparam int StopToStart = 16 + 2 + 15 + 16 + 2 + 4;
`else
    localparam int NWrites     = 3;
    localparam int RunCycles   = 10 + 3 * 466;
    localparam int StopToStart = 16 + 2 + 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic        sioc;
    logic        siod_o;
    logic        siod_oe;
    logic        busy;
    logic        cfg_done;

    int n_checks = 0;
    int n_errors = 0;

    ov_cfg_ctrl #(
        .CLK_DIV    (ClkDiv),
        .REG_NUM    (RegNum),
        .DEV_ADDR   (8'h42),
        .BOOT_WAIT  (BootWait),
        .DELAY_UNIT (DelayUnit)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sioc     (sioc),
        .siod_o   (siod_o),
        .siod_oe  (siod_oe),
        .busy     (busy),
        .cfg_done (cfg_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [7:0] a);
        case (a)
            8'd0:    return 16'h1280;
            8'd1:    return 16'hFF03;
            8'd2:    return 16'h1104;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom_word(rom_addr);

    // Entries that actually appear on the bus, in order.
    function automatic logic [15:0] exp_entry(input int w);
`ifdef OV_CFG_DELAY_ENTRY_EN
        return (w == 0) ? 16'h1280 : 16'h1104;
`else
        case (w)
            0:       return 16'h1280;
            1:       return 16'hFF03;
            default: return 16'h1104;
        endcase
`endif
    endfunction

    // Bus monitor, sampled on the falling edge.
    int   cyc = 0;
    logic p_sioc = 1'b1;
    logic p_siod = 1'b1;
    logic p_busy = 1'b0;
    logic p_done = 1'b0;
    logic [7:0] p_addr = 8'd0;
    int   q_edge[$];
    int   q_start[$];
    int   q_stop[$];
    int   q_addr[$];
    int   oe_low = 0;
    int   hi_chg = 0;
    int   busy_rise = 0;
    int   done_rise = 0;

    always @(negedge clk) begin
        if (sioc && !p_sioc) q_edge.push_back((siod_oe ? 2 : 0) + (siod_o ? 1 : 0));
        if (sioc && p_sioc && p_siod && !siod_o) q_start.push_back(cyc);
        if (sioc && p_sioc && !p_siod && siod_o) q_stop.push_back(cyc);
        if (sioc && p_sioc && (siod_o != p_siod)) hi_chg++;
        if (!siod_oe) oe_low++;
        if (rom_addr != p_addr) q_addr.push_back(int'(rom_addr));
        if (busy && !p_busy) busy_rise = cyc;
        if (cfg_done && !p_done) done_rise = cyc;
        p_sioc = sioc;
        p_siod = siod_o;
        p_busy = busy;
        p_done = cfg_done;
        p_addr = rom_addr;
        cyc++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full table run from rom_addr 0; optional extra start pulse mid-run.
    task automatic run_check(input string tag, input bit poke);
        int e0, s0, p0, a0, o0, h0, n, v, base;
        logic [7:0]  byte_v;
        logic [26:0] oe_v;
        logic [15:0] ent;
        e0 = q_edge.size();
        s0 = q_start.size();
        p0 = q_stop.size();
        a0 = q_addr.size();
        o0 = oe_low;
        h0 = hi_chg;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_val({tag, "_busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        while (!cfg_done && n < 5000) begin
            @(negedge clk);
            n++;
            start = (poke && n == 200);
        end
        start = 1'b0;
        check_val({tag, "_done"}, 32'(cfg_done), 32'd1);
        check_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check_val({tag, "_cycles"}, 32'(done_rise - busy_rise), 32'(RunCycles));
        check_val({tag, "_starts"}, 32'(q_start.size() - s0), 32'(NWrites));
        check_val({tag, "_stops"}, 32'(q_stop.size() - p0), 32'(NWrites));
        check_val({tag, "_sioc_high_chg"}, 32'(hi_chg - h0), 32'(2 * NWrites));
        check_val({tag, "_oe_low_cycles"}, 32'(oe_low - o0), 32'(48 * NWrites));
        check_val({tag, "_gap_stop_start"}, 32'(q_start[s0 + 1] - q_stop[p0]),
                  32'(StopToStart));
        check_val({tag, "_addr_steps"}, 32'(q_addr.size() - a0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val({tag, "_addr_seq"}, 32'(q_addr[a0 + i]), 32'(i + 1));
        end
        check_val({tag, "_rise_count"}, 32'(q_edge.size() - e0), 32'(28 * NWrites));
        for (int w = 0; w < NWrites; w++) begin
            base = e0 + w * 28;
            ent  = exp_entry(w);
            for (int p = 0; p < 3; p++) begin
                byte_v = '0;
                for (int k = 0; k < 8; k++) begin
                    v = q_edge[base + p * 9 + k];
                    byte_v = {byte_v[6:0], v[0]};
                end
                check_val({tag, "_byte"}, 32'(byte_v),
                          (p == 0) ? 32'h42 : (p == 1) ? 32'(ent[15:8]) : 32'(ent[7:0]));
            end
            oe_v = '0;
            for (int b = 0; b < 27; b++) begin
                v = q_edge[base + b];
                oe_v = {oe_v[25:0], v[1]};
            end
            check_val({tag, "_oe_pattern"}, 32'(oe_v), 32'(27'b111111110111111110111111110));
            v = q_edge[base + 27];
            check_val({tag, "_stop_rise_siod"}, 32'(v[0]), 32'd0);
        end
    endtask

    initial begin
        int n, p0;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_sioc", 32'(sioc), 32'd1);
        check_val("rst_siod", 32'(siod_o), 32'd1);
        check_val("rst_oe", 32'(siod_oe), 32'd1);
        check_val("rst_addr", 32'(rom_addr), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(cfg_done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_check("run1", 1'b1);

        // Reset in the middle of a shift on entry 1 or later.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (rom_addr != 8'd1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        while (siod_oe && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("mid_shift_reached", 32'(siod_oe), 32'd0);
        p0 = q_stop.size();
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_sioc", 32'(sioc), 32'd1);
        check_val("mid_rst_siod", 32'(siod_o), 32'd1);
        check_val("mid_rst_oe", 32'(siod_oe), 32'd1);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_addr", 32'(rom_addr), 32'd0);
        check_val("mid_rst_done", 32'(cfg_done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("mid_rst_no_stop", 32'(q_stop.size() - p0), 32'd0);

        // start coincident with rst: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_val("rst_start_busy", 32'(busy), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_val("rst_start_busy_after", 32'(busy), 32'd0);
        check_val("rst_start_addr", 32'(rom_addr), 32'd0);

        run_check("run2", 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
